// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for a shared single-port memory (optional round-robin tie-break via ARB_RR_EN)
//
// Two requesters share one single-port memory: instruction fetch (IF, read
// only) and data memory (DM, read or write). One transaction runs at a time.
// The FSM steps IDLE -> ACCESS (WAIT_CYCLES strobe cycles) -> RESP (one ack
// cycle) -> IDLE. Every output is a flop, so the memory strobes begin one
// cycle after the request is sampled.
//
// Build option:
//   ARB_RR_EN undefined : a tie goes to DM (fixed priority).
//   ARB_RR_EN defined   : a tie goes to the requester that was not granted
//                         last. Reset treats DM as granted last.
module mem_port_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ack,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic              o_dm_ack,
  output logic [DATA_W-1:0] o_dm_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [1:0]        o_grant,
  output logic              o_busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_IF   = 2'b01;
  localparam logic [1:0] GRANT_DM   = 2'b10;

  // Counter value on the final strobe cycle.
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  logic [1:0]        state_q;
  logic [3:0]        cnt_q;
  logic [1:0]        grant_q;
  logic              we_q;
  logic              busy_q;
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic              if_ack_q;
  logic              dm_ack_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rdata_q;

  // Arbitration result for the current cycle. This value is used only when
  // the FSM is in IDLE and at least one request is high.
  logic pick_dm;

`ifdef ARB_RR_EN
  logic last_dm_q;

  // Round-robin tie-break: on a tie, DM wins only when IF was granted last.
  always_comb begin
    pick_dm = 1'b0;
    if (i_dm_req && (!i_if_req || !last_dm_q)) begin
      pick_dm = 1'b1;
    end
  end

  // Record the most recent winner on every new grant.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      last_dm_q <= 1'b1;
    end else if (state_q == ST_IDLE && (i_if_req || i_dm_req)) begin
      last_dm_q <= pick_dm;
    end
  end
`else
  // Fixed priority: DM wins whenever it is requesting.
  always_comb begin
    pick_dm = i_dm_req;
  end
`endif

  // Transaction FSM: latch the winner, strobe memory, then acknowledge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      grant_q     <= GRANT_NONE;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_if_req || i_dm_req) begin
            state_q <= ST_ACCESS;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b1;
            if (pick_dm) begin
              grant_q     <= GRANT_DM;
              we_q        <= i_dm_we;
              mem_addr_q  <= i_dm_addr;
              mem_wdata_q <= i_dm_wdata;
              mem_rd_q    <= !i_dm_we;
              mem_wr_q    <= i_dm_we;
            end else begin
              // Fetches are always reads; the write-data bus keeps its
              // previous value because the memory ignores it on a read.
              grant_q    <= GRANT_IF;
              we_q       <= 1'b0;
              mem_addr_q <= i_if_addr;
              mem_rd_q   <= 1'b1;
              mem_wr_q   <= 1'b0;
            end
          end
        end

        ST_ACCESS: begin
          if (cnt_q == LAST_CNT) begin
            // Memory read data is valid only on the final strobe cycle.
            state_q  <= ST_RESP;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            if (!we_q) begin
              rdata_q <= i_mem_rdata;
            end
            if_ack_q <= (grant_q == GRANT_IF);
            dm_ack_q <= (grant_q == GRANT_DM);
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end

        ST_RESP: begin
          // The ack is issued even if the requester has dropped its request.
          state_q  <= ST_IDLE;
          if_ack_q <= 1'b0;
          dm_ack_q <= 1'b0;
          grant_q  <= GRANT_NONE;
          busy_q   <= 1'b0;
        end

        default: begin
          state_q  <= ST_IDLE;
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
          if_ack_q <= 1'b0;
          dm_ack_q <= 1'b0;
          grant_q  <= GRANT_NONE;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_if_ack    = if_ack_q;
  assign o_dm_ack    = dm_ack_q;
  assign o_if_rdata  = rdata_q;
  assign o_dm_rdata  = rdata_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_rd    = mem_rd_q;
  assign o_mem_wr    = mem_wr_q;
  assign o_grant     = grant_q;
  assign o_busy      = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, memory access cycles per transaction; legal range 1..15.
REQ-002 Parameter: ADDR_W, default 32, address width.
REQ-003 Parameter: DATA_W, default 32, data width.
REQ-004 Clock and reset: one clock; reset is synchronous and active-low.
REQ-005 Port: i_clk, in, 1, sole clock; all state changes on rising edge.
REQ-006 Port: i_rst_n, in, 1, synchronous active-low reset.
REQ-007 Port: i_if_req, in, 1, instruction-fetch read request; held high until o_if_ack.
REQ-008 Port: i_if_addr, in, ADDR_W, fetch address.
REQ-009 Port: o_if_ack, out, 1, one-cycle fetch completion pulse.
REQ-010 Port: o_if_rdata, out, DATA_W, fetched word; valid while o_if_ack=1.
REQ-011 Port: i_dm_req, in, 1, data request; held high until o_dm_ack.
REQ-012 Port: i_dm_we, in, 1, data request is a write (1) or read (0).
REQ-013 Port: i_dm_addr, in, ADDR_W, data address.
REQ-014 Port: i_dm_wdata, in, DATA_W, write data.
REQ-015 Port: o_dm_ack, out, 1, one-cycle data completion pulse.
REQ-016 Port: o_dm_rdata, out, DATA_W, read word; valid while o_dm_ack=1 on a read.
REQ-017 Port: o_mem_addr, out, ADDR_W, address to the shared single-port memory.
REQ-018 Port: o_mem_wdata, out, DATA_W, write data to memory.
REQ-019 Port: o_mem_rd, out, 1, memory read strobe.
REQ-020 Port: o_mem_wr, out, 1, memory write strobe.
REQ-021 Port: i_mem_rdata, in, DATA_W, memory read data; valid in the last ACCESS cycle.
REQ-022 Port: o_grant, out, 2, current owner: 00 none, 01 IF, 10 DM.
REQ-023 Port: o_busy, out, 1, high in any state other than IDLE.

Function
REQ-024 FSM states: IDLE, ACCESS, RESP; all outputs are registered.
REQ-025 IDLE: with any request high at an edge, latch winner, address, wdata and we, then enter ACCESS; otherwise remain in IDLE.
REQ-026 Arbitration default: when both requests are high, DM wins (fixed priority).
REQ-027 ACCESS: hold o_mem_addr/o_mem_wdata stable; assert o_mem_rd (read) or o_mem_wr (write) for exactly WAIT_CYCLES cycles, counted by a 4-bit counter cleared on entry.
REQ-028 On the last ACCESS cycle, capture i_mem_rdata for reads; writes leave the read-data register unchanged; then enter RESP.
REQ-029 RESP: pulse the winner's ack for one cycle with rdata valid, strobes low, then return to IDLE.
REQ-030 Latency: request first high in IDLE at cycle 0 -> strobes in cycles 1..WAIT_CYCLES -> ack in cycle WAIT_CYCLES+1; next grant no earlier than cycle WAIT_CYCLES+2.
REQ-031 Requests arriving while busy are not acknowledged until served; the losing requester stays pending, with no lost request.
REQ-032 A requester dropping req mid-transaction does not abort it; ack is still issued.
REQ-033 o_mem_rd and o_mem_wr are never high simultaneously; o_if_ack and o_dm_ack are never high simultaneously.
REQ-034 o_grant is non-zero exactly during ACCESS and RESP.

Reset
REQ-035 i_rst_n=0 at an edge forces IDLE, clears the counter, and sets o_grant=00, o_busy=0, all acks/strobes=0, rdata/addr/wdata registers=0.
REQ-036 Reset during ACCESS or RESP drops the transaction: no ack is issued, and strobes are low from the next edge.
REQ-037 With ARB_RR_EN, reset sets last-grant to DM, so the first tie goes to IF.

Configuration
REQ-038 Macro ARB_RR_EN defined: ties are resolved round-robin; the requester not granted last wins, and last-grant updates on every IDLE->ACCESS transition.
REQ-039 Macro ARB_RR_EN undefined: fixed DM priority per REQ-026; no last-grant register is built.

Verification (WAIT_CYCLES=2)
REQ-040 IF read 0x100, mem returns 0xDEADBEEF -> o_mem_rd high 2 cycles, o_if_ack at cycle 3 with o_if_rdata=0xDEADBEEF.
REQ-041 DM write 0x200<-0x12345678 -> o_mem_wr high 2 cycles with that addr/data, o_dm_ack at cycle 3, o_mem_rd never high.
REQ-042 IF and DM requests asserted in the same cycle, ARB_RR_EN undefined -> DM served first (ack cycle 3), IF ack at cycle 7.
REQ-043 Same stimulus repeated twice with ARB_RR_EN defined -> grants alternate IF, DM, IF, DM.
REQ-044 i_rst_n=0 for one cycle during the second ACCESS cycle -> next edge IDLE, strobes 0, no ack, o_grant=00.
REQ-045 Continuous IF req with DM req asserted mid-IF-transaction -> IF completes, DM granted next, no ack overlap.
